// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter.
// Three writeback sources (ALU, load, debug) each hand an address/data pair
// into a one-entry holding register. One holding register is granted per
// cycle and its contents drive the registered AD3/WD3/WE3 write port.
// Debug has fixed top priority. ALU and load share a 1-bit round-robin
// pointer. Writes to register 0 use a grant slot but never raise WE3.
module regfile_write_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDRESS_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic                     dbg_valid,
    output logic                     dbg_ready,
    input  logic [ADDRESS_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0]    dbg_data,
    output logic                     WE3,
    output logic [ADDRESS_WIDTH-1:0] AD3,
    output logic [DATA_WIDTH-1:0]    WD3,
    output logic                     busy
);

    // Index 0 = ALU, 1 = load, 2 = debug throughout.
    logic [2:0]               in_valid;
    logic [ADDRESS_WIDTH-1:0] in_addr [3];
    logic [DATA_WIDTH-1:0]    in_data [3];

    logic [2:0]               hv;
    logic [ADDRESS_WIDTH-1:0] ha [3];
    logic [DATA_WIDTH-1:0]    hd [3];
    logic                     rr;

    logic [2:0]               grant;
    logic [2:0]               ready;
    logic [2:0]               accept;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_data;

    assign in_valid   = {dbg_valid, ld_valid, alu_valid};
    assign in_addr[0] = alu_addr;
    assign in_addr[1] = ld_addr;
    assign in_addr[2] = dbg_addr;
    assign in_data[0] = alu_data;
    assign in_data[1] = ld_data;
    assign in_data[2] = dbg_data;

    // Pick one occupied holding register: debug first, then the rr-preferred of ALU/load
    always_comb begin
        grant = 3'b000;
        if (hv[2]) begin
            grant = 3'b100;
        end else if (hv[0] && hv[1]) begin
            grant = rr ? 3'b010 : 3'b001;
        end else if (hv[0]) begin
            grant = 3'b001;
        end else if (hv[1]) begin
            grant = 3'b010;
        end
    end

    // A slot can take a new entry when empty or when it is being drained this cycle.
    assign ready     = {3{~rst}} & (~hv | grant);
    assign accept    = in_valid & ready;
    assign alu_ready = ready[0];
    assign ld_ready  = ready[1];
    assign dbg_ready = ready[2];

    // Route the granted entry toward the write port
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                sel_addr = ha[i];
                sel_data = hd[i];
            end
        end
    end

    // Occupancy: set on accept, cleared on grant unless reloaded at the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hv <= 3'b000;
        end else begin
            hv <= accept | (hv & ~grant);
        end
    end

    // Capture payload on accept; contents are only observed while hv is set
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (accept[i]) begin
                ha[i] <= in_addr[i];
                hd[i] <= in_data[i];
            end
        end
    end

    // Round-robin pointer moves away from whichever of ALU/load was just served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= 1'b0;
        end else if (grant[0]) begin
            rr <= 1'b1;
        end else if (grant[1]) begin
            rr <= 1'b0;
        end
    end

    // Registered write port; x0 targets consume the slot with WE3 low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WE3 <= 1'b0;
            AD3 <= '0;
            WD3 <= '0;
        end else if (|grant) begin
            WE3 <= (sel_addr != '0);
            AD3 <= sel_addr;
            WD3 <= sel_data;
        end else begin
            WE3 <= 1'b0;
        end
    end

    assign busy = (|hv) | WE3;

endmodule
